// File: rtl/fetch_queue.sv
// fetch_queue: doubleword fetch, big-endian split into an instruction queue with redirect flush; FETCH_QUEUE_STATS_EN adds stat counters
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [0:63] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [0:63] redirect_pc,
  output logic        mem_req_valid,
  output logic [0:60] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [0:63] mem_resp_data,
  output logic        inst_valid,
  output logic [0:31] inst,
  output logic [0:63] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [0:31] stat_fetched,
  output logic [0:31] stat_discarded
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {REQ, WAIT, DISCARD} state_t;
  state_t state;
  logic [0:63] fetch_pc;
  logic [0:31] q_inst [DEPTH];
  logic [0:63] q_pc [DEPTH];
  logic [AW-1:0] head, tail, tail_nx;
  logic [AW:0] count;
  logic [1:0] push_n;
  logic pop, fire;
  always_comb begin
    mem_req_valid = rst_n && state == REQ && count <= (AW+1)'(DEPTH - 2);
    mem_req_addr = fetch_pc[0:60];
    fire = mem_req_valid && mem_req_ready;
    inst_valid = count != '0;
    inst = q_inst[head];
    inst_pc = q_pc[head];
    pop = inst_valid && inst_ready;
    push_n = state == WAIT && mem_resp_valid && !redirect_valid ? (fetch_pc[61] ? 2'd1 : 2'd2) : 2'd0;
    tail_nx = tail + AW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REQ;
      fetch_pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      state <= (state != REQ && !mem_resp_valid) || fire ? DISCARD : REQ;
      fetch_pc <= redirect_pc & ~64'h3;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      state <= fire ? WAIT : state != REQ && mem_resp_valid ? REQ : state;
      fetch_pc <= push_n != 2'd0 ? fetch_pc + (fetch_pc[61] ? 64'd4 : 64'd8) : fetch_pc;
      head <= head + AW'(pop);
      tail <= tail + AW'(push_n);
      count <= count + (AW+1)'(push_n) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      q_inst[tail] <= fetch_pc[61] ? mem_resp_data[32:63] : mem_resp_data[0:31];
      q_pc[tail] <= fetch_pc;
    end
    if (push_n == 2'd2) begin
      q_inst[tail_nx] <= mem_resp_data[32:63];
      q_pc[tail_nx] <= fetch_pc + 64'd4;
    end
  end
`ifdef FETCH_QUEUE_STATS_EN
  logic drop;
  assign drop = mem_resp_valid && (state == DISCARD || (state == WAIT && redirect_valid));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_discarded <= '0;
    end else begin
      stat_fetched <= stat_fetched + 32'(push_n);
      stat_discarded <= stat_discarded + 32'(drop);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, reset corner sequence and randomized stream check against a memory/PC model
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst_n, redirect_valid, mem_req_valid, mem_req_ready, mem_resp_valid, inst_valid, inst_ready;
  logic [0:63] redirect_pc, mem_resp_data, inst_pc;
  logic [0:60] mem_req_addr;
  logic [0:31] inst;
`ifdef FETCH_QUEUE_STATS_EN
  logic [0:31] stat_fetched, stat_discarded;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_discarded(stat_discarded)
`endif
  );
  typedef struct {
    logic rn, rd;
    logic [63:0] rpc;
    logic rdy, rvi;
    logic [63:0] data;
    logic ir, erv;
    logic [60:0] ea;
    logic eiv;
    logic [31:0] ei;
    logic [63:0] ep;
  } vec_t;
  function automatic vec_t mk(input logic rn, rd, input logic [63:0] rpc, input logic rdy, rvi,
                              input logic [63:0] data, input logic ir, erv, input logic [60:0] ea,
                              input logic eiv, input logic [31:0] ei, input logic [63:0] ep);
    vec_t v;
    v.rn = rn; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rvi = rvi; v.data = data; v.ir = ir;
    v.erv = erv; v.ea = ea; v.eiv = eiv; v.ei = ei; v.ep = ep;
    return v;
  endfunction
  function automatic logic [31:0] mem_word(input logic [63:0] pc);
    return pc[31:0] * 32'h9E37_79B1 ^ pc[63:32] ^ 32'h0F1E_2D3C;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input string tag);
    rst_n = v.rn;
    redirect_valid = v.rd;
    redirect_pc = v.rpc;
    mem_req_ready = v.rdy;
    mem_resp_valid = v.rvi;
    mem_resp_data = v.data;
    inst_ready = v.ir;
    #1;
    check({tag, " req_valid"}, 64'(mem_req_valid), 64'(v.erv));
    if (v.erv) check({tag, " req_addr"}, 64'(mem_req_addr), 64'(v.ea));
    check({tag, " inst_valid"}, 64'(inst_valid), 64'(v.eiv));
    if (v.eiv) begin
      check({tag, " inst"}, 64'(inst), 64'(v.ei));
      check({tag, " inst_pc"}, inst_pc, v.ep);
    end
    @(posedge clk);
    #1;
  endtask
  vec_t tbl[$];
  logic [63:0] exp_pc, base;
  logic [60:0] pend_addr, prev_addr;
  int pend, lat, pops;
  logic prev_hold;
  initial begin
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,64'h38000001_38000002,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,0, 1,61'h1,1,32'h38000001,64'h0));
    tbl.push_back(mk(1,0,0,0,1,64'h11111111_22222222,0, 0,0,1,32'h38000001,64'h0));
    tbl.push_back(mk(1,0,0,1,0,0,1, 0,0,1,32'h38000001,64'h0));
    tbl.push_back(mk(1,0,0,1,0,0,1, 0,0,1,32'h38000002,64'h4));
    tbl.push_back(mk(1,0,0,0,0,0,0, 1,61'h2,1,32'h11111111,64'h8));
    tbl.push_back(mk(1,0,0,1,0,0,1, 1,61'h2,1,32'h11111111,64'h8));
    tbl.push_back(mk(1,1,64'h107,0,0,0,0, 0,0,1,32'h22222222,64'hC));
    tbl.push_back(mk(1,0,0,0,1,64'hDEADBEEF_DEADBEEF,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,0, 1,61'h20,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,64'hAAAAAAAA_BBBBBBBB,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,1, 1,61'h21,1,32'hBBBBBBBB,64'h104));
    tbl.push_back(mk(1,1,64'h200,0,1,64'h12345678_9ABCDEF0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,1,64'h300,1,0,0,0, 1,61'h40,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,64'hCAFEF00D_CAFEF00D,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,0, 1,61'h60,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,64'h00000013_00000093,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 1,61'h61,1,32'h00000013,64'h300));
    tbl.push_back(mk(1,0,0,0,0,0,1, 1,61'h61,1,32'h00000093,64'h304));
    tbl.push_back(mk(1,0,0,0,0,0,0, 1,61'h61,0,0,0));
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));
`ifdef FETCH_QUEUE_STATS_EN
    check("stat_fetched", 64'(stat_fetched), 64'd7);
    check("stat_discarded", 64'(stat_discarded), 64'd3);
`endif
    apply(mk(1,0,0,1,0,0,0, 1,61'h61,0,0,0), "rA");
    apply(mk(1,0,0,0,1,64'h55555555_66666666,0, 0,0,0,0,0), "rB");
    apply(mk(1,0,0,1,0,0,0, 1,61'h62,1,32'h55555555,64'h308), "rC");
    apply(mk(0,0,0,0,0,0,0, 0,0,1,32'h55555555,64'h308), "rD");
    apply(mk(0,0,0,0,1,64'hDEADBEEF_DEADBEEF,0, 0,0,0,0,0), "rE");
`ifdef FETCH_QUEUE_STATS_EN
    check("stat_fetched reset", 64'(stat_fetched), 64'd0);
    check("stat_discarded reset", 64'(stat_discarded), 64'd0);
`endif
    apply(mk(1,0,0,0,0,0,0, 1,0,0,0,0), "rF");
    apply(mk(1,0,0,1,0,0,0, 1,0,0,0,0), "rG");
    apply(mk(1,0,0,0,1,64'h38000001_38000002,0, 0,0,0,0,0), "rH");
    apply(mk(1,0,0,0,0,0,0, 1,61'h1,1,32'h38000001,64'h0), "rI");
    rst_n = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = 64'h0;
    pend = 0;
    lat = 0;
    pend_addr = '0;
    prev_hold = 1'b0;
    prev_addr = '0;
    pops = 0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_hold) begin
        check("rand hold valid", 64'(mem_req_valid), 64'd1);
        check("rand hold addr", 64'(mem_req_addr), 64'(prev_addr));
      end
      redirect_valid = $urandom_range(0, 29) == 0;
      redirect_pc = $urandom_range(0, 3) == 0 ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                              : 64'($urandom_range(0, 4095));
      mem_req_ready = $urandom_range(0, 2) != 0;
      inst_ready = $urandom_range(0, 3) != 0;
      mem_resp_valid = pend != 0 && lat == 0;
      base = {pend_addr, 3'b000};
      mem_resp_data = mem_resp_valid ? {mem_word(base), mem_word(base + 64'd4)} : {$urandom, $urandom};
      #1;
      if (inst_valid && inst_ready) begin
        check("rand inst_pc", inst_pc, exp_pc);
        check("rand inst", 64'(inst), 64'(mem_word(exp_pc)));
        exp_pc += 64'd4;
        pops++;
      end
      if (mem_resp_valid) pend = 0;
      else if (pend != 0) lat--;
      if (mem_req_valid && mem_req_ready) begin
        check("rand one outstanding", 64'(pend), 64'd0);
        pend = 1;
        pend_addr = mem_req_addr;
        lat = $urandom_range(0, 2);
      end
      if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
      prev_hold = mem_req_valid && !mem_req_ready && !redirect_valid;
      prev_addr = mem_req_addr;
      @(posedge clk);
      #1;
    end
    check("rand progress", 64'(pops >= 300), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
